// File: rtl/fetch_queue_if.sv
// Fetch front-end bus bundle: instruction-memory request side and decoder side.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    // fetch_queue side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    // memory / decoder / branch-unit side
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: one outstanding memory request,
// a DEPTH-entry {pc, word} FIFO towards the decoder, and redirect flushing.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             req_q, req_d;
    logic             squash_q, squash_d;
    logic             valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      word_mem_q [DEPTH];

    logic complete;
    logic push;
    logic pop;

    // Next-state: completion/squash, FIFO bookkeeping, redirect and issue decision
    always_comb begin
        complete   = req_q & bus.imem_rvalid;
        // a word completing in a redirect cycle belongs to the old path
        push       = complete & ~squash_q & ~bus.redirect;
        pop        = valid_q & bus.instr_ready;

        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_d      = req_q;
        squash_d   = squash_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (bus.redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (push) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = req_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // the still-pending old-path request must be drained before refetching
        if (complete) begin
            squash_d = 1'b0;
        end else if (bus.redirect && req_q) begin
            squash_d = 1'b1;
        end

        if (!(req_q && !bus.imem_rvalid)) begin
            req_d    = (count_d < CNT_W'(DEPTH));
            req_pc_d = fetch_pc_d;
        end

        valid_d = (count_d != '0);
    end

    // State registers and FIFO storage
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            req_q      <= 1'b0;
            squash_q   <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= 32'h0;
                word_mem_q[i] <= 32'h0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            req_q      <= req_d;
            squash_q   <= squash_d;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (push) begin
                pc_mem_q[tail_q]   <= req_pc_q;
                word_mem_q[tail_q] <= bus.imem_rdata;
            end
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = req_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = word_mem_q[head_q];
    assign bus.instr_pc    = pc_mem_q[head_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle table, hand-written corner sequences,
// and randomized wait-state / backpressure / redirect traffic against a
// program-order reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk;
    logic rst;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_fail;
    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_hold;

    typedef struct {
        logic        rvalid;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [14];

    // memory contents are a fixed function of the word address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;
    endtask

    // returns positioned in cycle 0 (first cycle after rst is released)
    task automatic do_reset(input bit check);
        rst = 1'b1;
        drive_idle();
        mem_pend = 1'b0;
        mem_wait = 0;
        next_cycle();
        next_cycle();
        if (check) begin
            chk("rst_req",   32'(bus.imem_req), 32'h0);
            chk("rst_addr",  bus.imem_addr, RPC);
            chk("rst_valid", 32'(bus.instr_valid), 32'h0);
            chk("rst_instr", bus.instr, 32'h0);
            chk("rst_pc",    bus.instr_pc, 32'h0);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    // memory with per-request wait states; fixed_wait < 0 picks 0..max_wait
    task automatic mem_drive(input int fixed_wait, input int max_wait, output bit new_req);
        new_req = 1'b0;
        if (bus.imem_req) begin
            if (!mem_pend) begin
                new_req  = 1'b1;
                mem_hold = bus.imem_addr;
                mem_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
                chk("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'h0);
            end else begin
                chk("addr_hold", bus.imem_addr, mem_hold);
            end
            if (mem_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word_of(bus.imem_addr);
                mem_pend        = 1'b0;
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = $urandom;
                mem_pend        = 1'b1;
                mem_wait--;
            end
        end else begin
            mem_pend        = 1'b0;
            bus.imem_rvalid = 1'($urandom_range(1, 0));
            bus.imem_rdata  = $urandom;
        end
    endtask

    // delivered stream must be program order from the latest redirect target
    task automatic run_stream(input int ncyc, input int fixed_wait, input int max_wait,
                              input int ready_pct, input int redir_pct, output int pops);
        logic [31:0] exp_pc;
        logic [31:0] redir_tgt;
        bit          last_redir;
        bit          redir_pend;
        bit          nr;
        exp_pc     = RPC;
        redir_tgt  = 32'h0;
        last_redir = 1'b0;
        redir_pend = 1'b0;
        pops       = 0;
        for (int c = 0; c < ncyc; c++) begin
            mem_drive(fixed_wait, max_wait, nr);
            bus.instr_ready = (int'($urandom_range(99, 0)) < ready_pct);
            bus.redirect    = (int'($urandom_range(99, 0)) < redir_pct);
            bus.redirect_pc = $urandom;
            if (last_redir) begin
                chk("flush_valid", 32'(bus.instr_valid), 32'h0);
            end
            if (nr && redir_pend) begin
                chk("redir_addr", bus.imem_addr, redir_tgt);
                redir_pend = 1'b0;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                chk("pop_pc",    bus.instr_pc, exp_pc);
                chk("pop_instr", bus.instr, word_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (bus.redirect) begin
                exp_pc     = bus.redirect_pc & 32'hFFFF_FFFC;
                redir_tgt  = exp_pc;
                redir_pend = 1'b1;
            end
            last_redir = bus.redirect;
            next_cycle();
        end
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive_idle();

        // zero-wait memory, decoder stalled until cycle 6, then redirect with rvalid+pop
        //           rvalid ready redir rpc           req   addr          valid pc
        vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h4};
        vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'hC};
        vt[10] = '{1'b1, 1'b1, 1'b1, 32'h203, 1'b1, 32'h1C,  1'b1, 32'h10};
        vt[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        vt[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
        vt[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204};

        do_reset(1'b1);
        for (int i = 0; i < 14; i++) begin
            bus.imem_rvalid = vt[i].rvalid;
            bus.imem_rdata  = word_of(bus.imem_addr);
            bus.instr_ready = vt[i].ready;
            bus.redirect    = vt[i].redir;
            bus.redirect_pc = vt[i].rpc;
            chk($sformatf("tbl%0d_req", i), 32'(bus.imem_req), 32'(vt[i].e_req));
            if (vt[i].e_req) begin
                chk($sformatf("tbl%0d_addr", i), bus.imem_addr, vt[i].e_addr);
            end
            chk($sformatf("tbl%0d_valid", i), 32'(bus.instr_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), bus.instr_pc, vt[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), bus.instr, word_of(vt[i].e_pc));
            end
            next_cycle();
        end
        drive_idle();

        // redirect to 0x100 while the request to 0x8 is still waiting
        do_reset(1'b0);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = word_of(bus.imem_addr);
        chk("sq_c0_addr", bus.imem_addr, 32'h0);
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = word_of(bus.imem_addr);
        chk("sq_c1_addr", bus.imem_addr, 32'h4);
        next_cycle();
        bus.imem_rvalid = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        chk("sq_c2_addr",  bus.imem_addr, 32'h8);
        chk("sq_c2_valid", 32'(bus.instr_valid), 32'h1);
        next_cycle();
        bus.redirect = 1'b0;
        chk("sq_c3_valid", 32'(bus.instr_valid), 32'h0);
        chk("sq_c3_req",   32'(bus.imem_req), 32'h1);
        chk("sq_c3_addr",  bus.imem_addr, 32'h8);
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = word_of(bus.imem_addr);
        chk("sq_c4_addr",  bus.imem_addr, 32'h8);
        chk("sq_c4_valid", 32'(bus.instr_valid), 32'h0);
        next_cycle();
        bus.imem_rdata = word_of(bus.imem_addr);
        chk("sq_c5_req",   32'(bus.imem_req), 32'h1);
        chk("sq_c5_addr",  bus.imem_addr, 32'h100);
        chk("sq_c5_valid", 32'(bus.instr_valid), 32'h0);
        next_cycle();
        bus.instr_ready = 1'b1; bus.imem_rdata = word_of(bus.imem_addr);
        chk("sq_c6_valid", 32'(bus.instr_valid), 32'h1);
        chk("sq_c6_pc",    bus.instr_pc, 32'h100);
        chk("sq_c6_instr", bus.instr, word_of(32'h100));
        next_cycle();
        drive_idle();

        // one-cycle reset with two entries buffered and a request outstanding
        do_reset(1'b0);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = word_of(bus.imem_addr);
        next_cycle();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = word_of(bus.imem_addr);
        next_cycle();
        bus.imem_rvalid = 1'b0;
        chk("mr_c2_valid", 32'(bus.instr_valid), 32'h1);
        chk("mr_c2_req",   32'(bus.imem_req), 32'h1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("mr_c3_valid", 32'(bus.instr_valid), 32'h0);
        chk("mr_c3_req",   32'(bus.imem_req), 32'h0);
        chk("mr_c3_instr", bus.instr, 32'h0);
        chk("mr_c3_pc",    bus.instr_pc, 32'h0);
        next_cycle();
        chk("mr_c4_req",   32'(bus.imem_req), 32'h1);
        chk("mr_c4_addr",  bus.imem_addr, RPC);
        drive_idle();

        // zero-wait, always-ready: one instruction per cycle from cycle 1
        do_reset(1'b0);
        run_stream(10, 0, 0, 100, 0, pops);
        chk("zw_pops", 32'(pops), 32'd9);

        // 3-cycle memory: one word every third cycle
        do_reset(1'b0);
        run_stream(30, 2, 0, 100, 0, pops);
        chk("w3_pops", 32'(pops), 32'd9);

        // random wait states, backpressure and redirects
        do_reset(1'b0);
        run_stream(3000, -1, 3, 70, 4, pops);
        chk("rand_live", 32'(pops >= 300), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the CPU. It replaces the single-cycle fetcher's direct instruction-memory read with a prefetching unit:

- Sequential instruction words are fetched over a request/valid handshake that tolerates wait states.
- Fetched words are buffered with their PCs in a small FIFO.
- Words are handed to the decoder over a valid/ready handshake.
- A redirect from branch/jump resolution flushes buffered and in-flight fetches.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request outstanding.
- imem_addr  out  32  fetch word address; bits [1:0] always 0; stable while imem_req=1.
- imem_rvalid  in  1  completes the outstanding request this cycle. Ignored when imem_req=0. May arrive in the same cycle imem_req first rises (zero-wait memory).
- imem_rdata  in  32  instruction word; sampled when imem_req & imem_rvalid.
- redirect  in  1  taken branch/jump; one-cycle pulse.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored.
- instr_valid  out  1  FIFO head valid.
- instr  out  32  FIFO head instruction word.
- instr_pc  out  32  FIFO head PC.
- instr_ready  in  1  decoder accepts head; pop when instr_valid & instr_ready.

## Operation

- State:
  - fetch_pc: next address to request.
  - imem_req register and req_pc, which drives imem_addr.
  - squash flag.
  - FIFO of {pc, word}: DEPTH entries, head/tail pointers, count 0..DEPTH.
- At most one request is outstanding.
  - A request completes on imem_req & imem_rvalid.
  - While outstanding (imem_req=1, no rvalid), req_pc and imem_req hold.
- On completion, the handling depends on squash:
  - squash=0: push {req_pc, imem_rdata}; fetch_pc = req_pc+4, modulo 2^32.
  - squash=1: discard the data and clear squash.
- Issue rule: at each edge where no request remains outstanding, imem_req_next = (count_next < DEPTH).
  - On issue, req_pc = fetch_pc (post-update).
  - count_next includes this cycle's push, pop and flush.
  - Invariant: count + imem_req <= DEPTH.
- Pop: when instr_valid & instr_ready, advance head and decrement count. Simultaneous push and pop leaves count unchanged.
- Redirect has priority over everything:
  - Flush the FIFO (count=0). The pop in the same cycle counts as accepted.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - If a request is outstanding and imem_rvalid=0: set squash, keep imem_req high at the old address until rvalid, discard that response, then issue at the redirect PC.
  - If imem_rvalid=1 in the redirect cycle: drop that word; no squash is set.
  - If nothing is outstanding: the next cycle requests the redirect PC.
- Redirect while squash=1: squash stays set and fetch_pc takes the newest redirect_pc.
- Full FIFO: no request issued; resumes the cycle after a pop brings count_next below DEPTH.
- Outputs instr/instr_pc come from the head entry. They are meaningful only when instr_valid=1. Entries are cleared on reset.

## Timing

- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - squash=0, count=0, fetch_pc=RESET_PC.
- Reset mid-operation discards any outstanding request. The memory must drop it; rvalid is ignored while imem_req=0.
- First request: imem_req=1 in the first cycle after rst deasserts (cycle 0).
- Latency: a word completing in cycle N is at the FIFO head in N+1, with instr_valid=1 if the FIFO was empty. There is no bypass.
- Zero-wait memory with a ready decoder sustains one instruction per cycle.
- Redirect in cycle R with nothing outstanding: imem_addr=redirect PC in R+1; the first redirected instruction is valid at the earliest in R+2.

## Test plan

- Zero-wait memory, instr_ready=1, RESET_PC=0 → imem_addr 0,4,8,… in cycles 0,1,2; instr_pc 0,4,8 valid from cycle 1, one per cycle.
- instr_ready=0, zero-wait memory, DEPTH=4 → four requests (0..C); imem_req=0 from cycle 4. Raise ready in cycle 6 → pop 0 in cycle 6; request 0x10 issued in cycle 7.
- Memory with 3-cycle wait → imem_req and imem_addr stable for 3 cycles; one word per 3 cycles; order preserved.
- Redirect to 0x100 while a request to 0x8 is outstanding (rvalid 2 cycles later) → FIFO empty the next cycle; the 0x8 data is never presented; the next imem_addr is 0x100; the first valid instr_pc is 0x100.
- Redirect to 0x203, with rvalid and pop in the same cycle → that word is dropped, the popped word is accepted, and imem_addr=0x200 the next cycle.
- rst asserted for one cycle mid-stream with 2 entries buffered → next cycle instr_valid=0; imem_req=1 at RESET_PC the cycle after rst falls.
